// File: rtl/regbank_writeback_queue_if.sv
// Bundle of producer handshakes, bank write port and decode hazard lookup
// for the register-bank writeback queue.
// master: the queue itself (accepts results, drives the bank write port).
// slave : the surrounding pipeline (producers, bank, decode).
`timescale 1ns/1ps
interface regbank_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ALU producer
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    // Memory/load producer
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    // Bank write port
    logic              wb_stall;
    logic              wEnable;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] rdIn;

    // Decode hazard lookup
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_busy;
    logic              rt_busy;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Occupancy
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  wb_stall,
        output wEnable, rd, rdIn,
        input  rs, rt,
        output rs_busy, rt_busy, rs_fwd, rt_fwd,
        output count, full, empty
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output wb_stall,
        input  wEnable, rd, rdIn,
        output rs, rt,
        input  rs_busy, rt_busy, rs_fwd, rt_fwd,
        input  count, full, empty
    );
endinterface

// File: rtl/regbank_writeback_queue.sv
// In-order writeback queue in front of the 32x32 register bank's single
// write port. Memory results win arbitration over ALU results; one push and
// one bank write per cycle. Pending-write flags let decode spot RAW hazards.
// Optional macro WB_BYPASS_EN: when defined, rs_fwd/rt_fwd return the data
// of the youngest queued write to the operand; otherwise they are tied to 0.
`timescale 1ns/1ps
module regbank_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                        clk,
    input logic                        rst,
    regbank_writeback_queue_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic              is_full;
    logic              is_empty;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;
    logic              rs_hit;
    logic              rt_hit;

    // Occupancy status, arbitration and write-port drive from registered state.
    always_comb begin
        is_full    = (cnt == CNT_W'(DEPTH));
        is_empty   = (cnt == '0);
        // Readies never look at this cycle's pop, so a full queue refuses a
        // push even while it is draining.
        push       = !is_full && (bus.mem_valid || bus.alu_valid);
        push_entry = bus.mem_valid ? entry_t'{rd: bus.mem_rd, data: bus.mem_data}
                                   : entry_t'{rd: bus.alu_rd, data: bus.alu_data};
        head       = entries[rd_ptr];
        pop        = !is_empty && !bus.wb_stall;
    end

    assign bus.mem_ready = !is_full;
    assign bus.alu_ready = !is_full && !bus.mem_valid;
    assign bus.wEnable   = pop;
    assign bus.rd        = is_empty ? '0 : head.rd;
    assign bus.rdIn      = is_empty ? '0 : head.data;
    assign bus.count     = cnt;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would let later lines see
            // half-updated state and break simulation/synthesis agreement.
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage, written at the tail on an accepted push.
    // NOTE: payload has no reset; the valid bits alone decide whether an
    // entry is live, so clearing the storage array would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Hazard flags: any live entry (including one popping now) targeting rs/rt.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no
        // latch is inferred.
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (entries[i].rd == bus.rs)) rs_hit = 1'b1;
            if (vld[i] && (entries[i].rd == bus.rt)) rt_hit = 1'b1;
        end
    end

    assign bus.rs_busy = rs_hit;
    assign bus.rt_busy = rt_hit;

`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [PTR_W-1:0]  scan_idx;

    // Youngest-match forwarding: walk from head to tail, later hits override.
    always_comb begin
        rs_data  = '0;
        rt_data  = '0;
        scan_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr + PTR_W'(k);
            if (vld[scan_idx] && (entries[scan_idx].rd == bus.rs)) rs_data = entries[scan_idx].data;
            if (vld[scan_idx] && (entries[scan_idx].rd == bus.rt)) rt_data = entries[scan_idx].data;
        end
    end

    assign bus.rs_fwd = rs_data;
    assign bus.rt_fwd = rt_data;
`else
    assign bus.rs_fwd = '0;
    assign bus.rt_fwd = '0;
`endif

endmodule

// File: tb/tb_regbank_writeback_queue.sv
// Self-checking bench for regbank_writeback_queue: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_regbank_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk;
    logic rst;

    regbank_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regbank_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   passed = 0;
    int   total  = 0;
    ent_t q[$];                    // reference queue, index 0 = oldest
    logic [ADDR_W-1:0] wlog[$];    // register indices the DUT actually wrote
    logic mem_acc;
    logic alu_acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: compare every output against the model at the falling edge,
    // advance the model, then return 1ns after the rising edge.
    task automatic cycle();
        int n;
        logic exp_we;
        logic [ADDR_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_din;
        logic bs, bt;
        logic [DATA_W-1:0] fs, ft;
        logic mr, ar;
        @(negedge clk);
        n       = q.size();
        mr      = (n < DEPTH);
        ar      = (n < DEPTH) && !bus.mem_valid;
        exp_we  = (n > 0) && !bus.wb_stall;
        exp_rd  = (n > 0) ? q[0].rd   : '0;
        exp_din = (n > 0) ? q[0].data : '0;
        bs = 1'b0; bt = 1'b0; fs = '0; ft = '0;
        foreach (q[i]) begin
            if (q[i].rd == bus.rs) begin bs = 1'b1; fs = q[i].data; end
            if (q[i].rd == bus.rt) begin bt = 1'b1; ft = q[i].data; end
        end
`ifndef WB_BYPASS_EN
        fs = '0;
        ft = '0;
`endif
        check("count",     32'(bus.count), 32'(n));
        check("full",      32'(bus.full),  32'(n == DEPTH));
        check("empty",     32'(bus.empty), 32'(n == 0));
        check("mem_ready", 32'(bus.mem_ready), 32'(mr));
        check("alu_ready", 32'(bus.alu_ready), 32'(ar));
        check("wEnable",   32'(bus.wEnable), 32'(exp_we));
        check("rd",        32'(bus.rd),   32'(exp_rd));
        check("rdIn",      bus.rdIn,      exp_din);
        check("rs_busy",   32'(bus.rs_busy), 32'(bs));
        check("rt_busy",   32'(bus.rt_busy), 32'(bt));
        check("rs_fwd",    bus.rs_fwd, fs);
        check("rt_fwd",    bus.rt_fwd, ft);
        if (bus.wEnable === 1'b1) wlog.push_back(bus.rd);
        mem_acc = bus.mem_valid && mr && rst;
        alu_acc = bus.alu_valid && ar && rst;
        if (rst) begin
            if (exp_we) void'(q.pop_front());
            if (mem_acc)      q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
            else if (alu_acc) q.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int i;
        logic [DATA_W-1:0] exp_fwd;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.wb_stall  = 0; bus.rs = '0; bus.rt = '0;
        mem_acc = 0; alu_acc = 0;
        rst = 1'b0;

        // Reset held for two cycles, then idle.
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        check("idle_empty",     32'(bus.empty), 32'd1);
        check("idle_count",     32'(bus.count), 32'd0);
        check("idle_wEnable",   32'(bus.wEnable), 32'd0);
        check("idle_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("idle_mem_ready", 32'(bus.mem_ready), 32'd1);
        cycle();

        // Single ALU push, written the following cycle.
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEADBEEF;
        cycle();
        bus.alu_valid = 0;
        #1;
        check("single_wEnable", 32'(bus.wEnable), 32'd1);
        check("single_rd",      32'(bus.rd), 32'd7);
        check("single_rdIn",    bus.rdIn, 32'hDEADBEEF);
        cycle();
        check("single_drained", 32'(bus.empty), 32'd1);
        cycle();

        // Both producers valid: memory first, ALU held and taken next.
        bus.mem_valid = 1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
        bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
        #1;
        check("arb_mem_ready", 32'(bus.mem_ready), 32'd1);
        check("arb_alu_ready", 32'(bus.alu_ready), 32'd0);
        cycle();
        bus.mem_valid = 0;
        #1;
        check("arb_w1_rd",   32'(bus.rd), 32'd3);
        check("arb_w1_data", bus.rdIn, 32'h11);
        check("arb_alu_now", 32'(bus.alu_ready), 32'd1);
        cycle();
        bus.alu_valid = 0;
        #1;
        check("arb_w2_we",   32'(bus.wEnable), 32'd1);
        check("arb_w2_rd",   32'(bus.rd), 32'd4);
        check("arb_w2_data", bus.rdIn, 32'h22);
        cycle();

        // Stall with five pushes: fill to four, fifth held until space.
        bus.wb_stall = 1;
        i = 1;
        bus.alu_valid = 1;
        for (int c = 0; c < 7; c++) begin
            bus.alu_rd = ADDR_W'(i); bus.alu_data = 32'(i) * 32'h100;
            cycle();
            if (alu_acc && i < 5) i++;
        end
        #1;
        check("stall_full",      32'(bus.full), 32'd1);
        check("stall_count",     32'(bus.count), 32'd4);
        check("stall_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("stall_held_r5",   32'(i), 32'd5);
        bus.wb_stall = 0;
        wlog.delete();
        for (int c = 0; c < 12 && (q.size() != 0 || bus.alu_valid); c++) begin
            cycle();
            if (alu_acc) bus.alu_valid = 0;
        end
        check("stall_drain_done", 32'(bus.empty), 32'd1);
        check("stall_nwrites", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("stall_order_%0d", k), (k < wlog.size()) ? 32'(wlog[k]) : 32'hFFFF_FFFF, 32'(k + 1));

        // Hazard: two queued writes to r9, youngest value forwarded.
        bus.wb_stall = 1;
        bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h5;
        cycle();
        bus.alu_data = 32'h6;
        cycle();
        bus.alu_valid = 0; bus.rs = 5'd9; bus.rt = 5'd2;
        #1;
`ifdef WB_BYPASS_EN
        exp_fwd = 32'h6;
`else
        exp_fwd = 32'h0;
`endif
        check("haz_rs_busy", 32'(bus.rs_busy), 32'd1);
        check("haz_rt_busy", 32'(bus.rt_busy), 32'd0);
        check("haz_rs_fwd",  bus.rs_fwd, exp_fwd);
        check("haz_rt_fwd",  bus.rt_fwd, 32'h0);
        cycle();
        bus.wb_stall = 0;
        repeat (3) cycle();

        // Entry being pushed is not busy; entry popping this cycle is.
        bus.alu_valid = 1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC0FFEE; bus.rs = 5'd12;
        #1;
        check("push_not_busy", 32'(bus.rs_busy), 32'd0);
        cycle();
        bus.alu_valid = 0;
        #1;
        check("pop_still_busy", 32'(bus.rs_busy), 32'd1);
        check("pop_we",         32'(bus.wEnable), 32'd1);
        cycle();

        // Reset mid-operation with three queued writes.
        bus.wb_stall = 1;
        bus.mem_valid = 1;
        for (int c = 0; c < 3; c++) begin
            bus.mem_rd = ADDR_W'(20 + c); bus.mem_data = 32'hA0 + 32'(c);
            cycle();
        end
        bus.mem_valid = 0; bus.rs = 5'd20; bus.rt = 5'd22;
        #1;
        check("pre_rst_count", 32'(bus.count), 32'd3);
        rst = 1'b0;
        #1;
        check("rst_wEnable", 32'(bus.wEnable), 32'd0);
        check("rst_empty",   32'(bus.empty), 32'd1);
        check("rst_count",   32'(bus.count), 32'd0);
        check("rst_rs_busy", 32'(bus.rs_busy), 32'd0);
        check("rst_rt_busy", 32'(bus.rt_busy), 32'd0);
        check("rst_rs_fwd",  bus.rs_fwd, 32'h0);
        q.delete();
        bus.wb_stall = 0;
        cycle();
        rst = 1'b1;
        wlog.delete();
        repeat (4) cycle();
        check("rst_no_writes", 32'(wlog.size()), 32'd0);

        // Randomized traffic over a small register range to provoke hazards.
        for (int c = 0; c < 300; c++) begin
            if (!bus.mem_valid && $urandom_range(0, 2) == 0) begin
                bus.mem_valid = 1; bus.mem_rd = ADDR_W'($urandom_range(0, 7)); bus.mem_data = $urandom;
            end
            if (!bus.alu_valid && $urandom_range(0, 1) == 0) begin
                bus.alu_valid = 1; bus.alu_rd = ADDR_W'($urandom_range(0, 7)); bus.alu_data = $urandom;
            end
            bus.wb_stall = ($urandom_range(0, 3) == 0);
            bus.rs = ADDR_W'($urandom_range(0, 7));
            bus.rt = ADDR_W'($urandom_range(0, 7));
            cycle();
            if (mem_acc) bus.mem_valid = 0;
            if (alu_acc) bus.alu_valid = 0;
        end
        bus.mem_valid = 0; bus.alu_valid = 0; bus.wb_stall = 0;
        repeat (DEPTH + 1) cycle();
        check("final_empty", 32'(bus.empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regbank_writeback_queue.md
Name: regbank_writeback_queue

Overview:
- Write-side initiator for the 32x32 register bank.
- Collects destination-register results from two producers, the single-cycle ALU and the multi-cycle memory/load path, through valid/ready handshakes.
- Buffers results in an in-order FIFO and drives the bank's single write port (wEnable/rd/rdIn) at one write per cycle.
- Exports per-operand pending flags so decode can detect RAW hazards against queued writes.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
DATA_W, 32, result data width; matches bank register width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when alu_valid=1
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  memory/load result offered
mem_ready  output  1  memory result accepted this cycle when mem_valid=1
mem_rd  input  ADDR_W  memory destination register
mem_data  input  DATA_W  memory result
wb_stall  input  1  bank write port unavailable this cycle
wEnable  output  1  bank write enable
rd  output  ADDR_W  bank write address
rdIn  output  DATA_W  bank write data
rs  input  ADDR_W  decode source operand 1 index
rt  input  ADDR_W  decode source operand 2 index
rs_busy  output  1  a queued write targets rs
rt_busy  output  1  a queued write targets rt
rs_fwd  output  DATA_W  forwarded data for rs (see Optional Feature)
rt_fwd  output  DATA_W  forwarded data for rt (see Optional Feature)
count  output  $clog2(DEPTH+1)  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (rst=0, async): write ptr, read ptr and count cleared to 0; all entry valid bits cleared.
  - Reset outputs: empty=1, full=0, wEnable=0, rs_busy=rt_busy=0, rs_fwd=rt_fwd=0.
  - Reset mid-operation flushes all queued writes; none reach the bank. Bank contents are untouched by this block.
- Push arbitration: at most one push per cycle; memory has priority over ALU.
  - mem_ready = !full
  - alu_ready = !full && !mem_valid
  - The ready signals depend only on registered state and the *_valid inputs, never on same-cycle pop.
  - When full, no push occurs even if a pop happens the same cycle.
- Push: the accepted {rd, data} is written at the tail on the clock edge; tail pointer wraps modulo DEPTH.
- Write port: driven combinationally from the head entry.
  - wEnable = !empty && !wb_stall; rd and rdIn come from the head entry.
  - rd/rdIn are 0 when empty.
- Pop: occurs on an edge where wEnable=1; head pointer wraps modulo DEPTH.
- Latency: a result accepted at edge N is written to the bank at edge N+1 when the queue was empty and wb_stall=0. Otherwise it is written in FIFO order.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: writes reach the bank strictly in acceptance order. Two queued writes to the same register leave the later value in the bank.
- Register 0 is an ordinary writable register; no special-casing.
- Busy flags are combinational.
  - rs_busy is set if any valid entry has rd == rs; rt_busy likewise for rt.
  - An entry popping this cycle still counts as busy. The entry being pushed this cycle does not.
- Width: count never exceeds DEPTH; the pointer arithmetic uses ADDR bits of $clog2(DEPTH).

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - rs_fwd returns the data of the youngest valid entry whose rd == rs, or 0 if there is no match; rt_fwd likewise.
  - Youngest means closest to the tail.
- Undefined:
  - rs_fwd and rt_fwd are tied to 0 and no comparison/priority logic for data is built.
  - rs_busy and rt_busy still operate.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> empty=1, count=0, wEnable=0, alu_ready=1, mem_ready=1.
- Single ALU push alu_rd=7, alu_data=0xDEADBEEF, wb_stall=0 -> next cycle wEnable=1, rd=7, rdIn=0xDEADBEEF; following cycle empty=1.
- Both valid same cycle, mem_rd=3/0x11 and alu_rd=4/0x22 -> mem accepted and alu_ready=0 that cycle. With alu held valid, bank writes are r3=0x11 then r4=0x22 on consecutive cycles.
- wb_stall=1 with 5 pushes (r1..r5) -> after 4 accepts full=1, count=4, ready=0 and r5 held. Release stall -> writes r1..r4 in order, then r5 accepted and written.
- Hazard: queue r9=0x5, then r9=0x6; rs=9, rt=2 -> rs_busy=1, rt_busy=0; with WB_BYPASS_EN rs_fwd=0x6, without it rs_fwd=0.
- Reset mid-operation with count=3 -> rst low clears queue immediately: wEnable=0, empty=1, busy flags 0; no further bank writes after release.
